counter: RTL and testbench

- 4-bit program counter (PC) for the small 4-bit CPU; it sits between the control unit and instruction memory.
- On each rising clock edge it advances by one when an instruction fetch is enabled, loads an absolute jump target, or holds.
- Its output drives the instruction-memory address.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/counter.sv | 63 ++++++
 tb/tb_counter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the small 4-bit CPU.
// Program-counter width, reset vector and next-PC selection helper.
package cpu_pkg;

  localparam int PC_WIDTH = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t RESET_PC = '0;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_JUMP,
    PC_INC
  } pc_op_e;

  // halt beats jump, jump beats increment
  function automatic pc_op_e pc_sel(
    input logic halt,
    input logic jump_en,
    input logic ir_load_en
  );
    pc_op_e op;
    op = PC_HOLD;
    if (halt)            op = PC_HOLD;
    else if (jump_en)    op = PC_JUMP;
    else if (ir_load_en) op = PC_INC;
    return op;
  endfunction

endpackage

// File: rtl/counter.sv
// Program counter: increment, absolute jump or hold; async active-low reset.
// Optional sticky wrap_flag output when COUNTER_WRAP_FLAG_EN is defined.
module counter #(
  parameter int PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC =
    PC_WIDTH'(cpu_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic                halt,
  input  logic                ir_load_en,
`ifdef COUNTER_WRAP_FLAG_EN
  output logic                wrap_flag,
`endif
  output logic [PC_WIDTH-1:0] pc_out
);

  import cpu_pkg::pc_op_e;
  import cpu_pkg::pc_sel;

  pc_op_e              op;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  always_comb begin
    op   = pc_sel(halt, jump_en, ir_load_en);
    pc_d = pc_q;
    case (op)
      cpu_pkg::PC_JUMP: pc_d = jump_addr;
      cpu_pkg::PC_INC:  pc_d = pc_q + PC_WIDTH'(1);
      default:          pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_out = pc_q;

`ifdef COUNTER_WRAP_FLAG_EN
  logic wrap_d;
  logic wrap_q;

  // only an increment out of all-ones counts; a jump to 0 does not
  always_comb begin
    wrap_d = wrap_q;
    if (op == cpu_pkg::PC_INC && (&pc_q))
      wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap_flag = wrap_q;
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: scoreboard of expected PC values.
// Build with COUNTER_WRAP_FLAG_EN to also check wrap_flag.
module tb_counter;

  logic       clk;
  logic       reset;
  logic       jump_en;
  logic [3:0] jump_addr;
  logic       halt;
  logic       ir_load_en;
  logic [3:0] pc_out;
`ifdef COUNTER_WRAP_FLAG_EN
  logic       wrap_flag;
`endif

  int compared;
  int mismatched;

  typedef struct {
    logic       h;
    logic       j;
    logic [3:0] ja;
    logic       ir;
    logic [3:0] pc;
    logic       f;
  } row_t;

  typedef struct {
    logic [3:0] pc;
    logic       f;
  } exp_t;

  exp_t sb[$];

  counter dut (
    .clk        (clk),
    .reset      (reset),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halt       (halt),
    .ir_load_en (ir_load_en),
`ifdef COUNTER_WRAP_FLAG_EN
    .wrap_flag  (wrap_flag),
`endif
    .pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input row_t r);
    exp_t e;
    @(negedge clk);
    halt       = r.h;
    jump_en    = r.j;
    jump_addr  = r.ja;
    ir_load_en = r.ir;
    e.pc = r.pc;
    e.f  = r.f;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; halt = 0; jump_en = 0;
    jump_addr = 4'h0; ir_load_en = 0;
    #14;
    compared++;
    if (pc_out !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_hold pc_out got %b want 0000", pc_out);
    end
`ifdef COUNTER_WRAP_FLAG_EN
    compared++;
    if (wrap_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flag wrap_flag got %b want 0", wrap_flag);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_count();
    row_t rows[4] = '{
      '{1'b0, 1'b0, 4'h0, 1'b1, 4'b0001, 1'b0},
      '{1'b0, 1'b0, 4'h0, 1'b1, 4'b0010, 1'b0},
      '{1'b0, 1'b0, 4'h0, 1'b1, 4'b0011, 1'b0},
      '{1'b0, 1'b0, 4'h0, 1'b1, 4'b0100, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      compared++;
      if (pc_out !== e.pc) begin
        mismatched++;
        $display("FAIL count[%0d] pc_out got %b want %b", i, pc_out, e.pc);
      end
    end
  endtask

  task automatic test_halt();
    row_t rows[4] = '{
      '{1'b1, 1'b0, 4'h0,    1'b1, 4'b0100, 1'b0},
      '{1'b1, 1'b1, 4'b1010, 1'b1, 4'b0100, 1'b0},
      '{1'b1, 1'b0, 4'h0,    1'b1, 4'b0100, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b0101, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      compared++;
      if (pc_out !== e.pc) begin
        mismatched++;
        $display("FAIL halt[%0d] pc_out got %b want %b", i, pc_out, e.pc);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    #1;
    compared++;
    if (pc_out !== 4'b0000) begin
      mismatched++;
      $display("FAIL async_reset pc_out got %b want 0000", pc_out);
    end
    @(negedge clk);
    halt = 1; jump_en = 1; jump_addr = 4'h9; ir_load_en = 1;
    @(posedge clk);
    #1;
    compared++;
    if (pc_out !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_override pc_out got %b want 0000", pc_out);
    end
    @(negedge clk);
    halt = 0; jump_en = 0; jump_addr = 4'h0; ir_load_en = 0;
    reset = 1'b1;
  endtask

  task automatic test_jump();
    row_t rows[10] = '{
      '{1'b0, 1'b1, 4'b1010, 1'b1, 4'b1010, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b1011, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b1100, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b1101, 1'b0},
      '{1'b0, 1'b1, 4'b1010, 1'b0, 4'b1010, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b0, 4'b1010, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b0, 4'b1010, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b0, 4'b1010, 1'b0},
      '{1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111, 1'b0},
      '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      compared++;
      if (pc_out !== e.pc) begin
        mismatched++;
        $display("FAIL jump[%0d] pc_out got %b want %b", i, pc_out, e.pc);
      end
`ifdef COUNTER_WRAP_FLAG_EN
      compared++;
      if (wrap_flag !== e.f) begin
        mismatched++;
        $display("FAIL jump_flag[%0d] wrap_flag got %b want %b",
                 i, wrap_flag, e.f);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[4] = '{
      '{1'b0, 1'b1, 4'b0011, 1'b1, 4'b0011, 1'b0},
      '{1'b0, 1'b1, 4'b0011, 1'b1, 4'b0011, 1'b0},
      '{1'b0, 1'b1, 4'b0011, 1'b1, 4'b0011, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b0100, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      compared++;
      if (pc_out !== e.pc) begin
        mismatched++;
        $display("FAIL b2b_jump[%0d] pc_out got %b want %b", i, pc_out, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[5] = '{
      '{1'b0, 1'b1, 4'b1110, 1'b1, 4'b1110, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b1111, 1'b0},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b0000, 1'b1},
      '{1'b0, 1'b0, 4'h0,    1'b1, 4'b0001, 1'b1},
      '{1'b1, 1'b0, 4'h0,    1'b1, 4'b0001, 1'b1}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      compared++;
      if (pc_out !== e.pc) begin
        mismatched++;
        $display("FAIL wrap[%0d] pc_out got %b want %b", i, pc_out, e.pc);
      end
`ifdef COUNTER_WRAP_FLAG_EN
      compared++;
      if (wrap_flag !== e.f) begin
        mismatched++;
        $display("FAIL wrap_flag[%0d] wrap_flag got %b want %b",
                 i, wrap_flag, e.f);
      end
`endif
    end
    @(negedge clk);
    halt = 0; ir_load_en = 0;
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (pc_out !== 4'b0000) begin
      mismatched++;
      $display("FAIL wrap_reset pc_out got %b want 0000", pc_out);
    end
`ifdef COUNTER_WRAP_FLAG_EN
    compared++;
    if (wrap_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_clear wrap_flag got %b want 0", wrap_flag);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_count();
    test_halt();
    test_async_reset();
    test_jump();
    test_back_to_back();
    test_wrap();
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
